// File: rtl/pea_pkg.sv
// Shared types for the PE-array sequencer.
// State encoding, latched pass config and delay-line tag.
package pea_pkg;

  localparam int CFG_W  = 8;
  localparam int KERNEL = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_PRIME,
    S_RUN,
    S_DRAIN,
    S_DONE
  } pea_ctrl_state_e;

  typedef struct packed {
    logic             stride;
    logic [CFG_W-1:0] ic;
    logic [CFG_W-1:0] oc;
    logic [CFG_W-1:0] steps;
  } pea_cfg_t;

  typedef struct packed {
    logic step;
    logic ic_last;
    logic oc_last;
  } pea_tag_t;

  // A zero count means one pass, never 2^CFG_W.
  function automatic logic [CFG_W-1:0] nz(
    input logic [CFG_W-1:0] v
  );
    return (v == '0) ? CFG_W'(1) : v;
  endfunction

endpackage

// File: rtl/pea_ctrl_dly.sv
// Fixed-latency tag pipe from ifm_read to psum valid.
// pend flags beats not yet at the output stage.
module pea_ctrl_dly
  import pea_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic     clk,
  input  logic     rstn,
  input  pea_tag_t d,
  output pea_tag_t q,
  output logic     pend
);

  pea_tag_t sr [LAT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LAT; i++)
        sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < LAT; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign q = sr[LAT-1];

  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < LAT - 1; i++)
      pend = pend | sr[i].step;
  end

endmodule

// File: rtl/pea_ctrl.sv
// Sequencer for the 3x3 PE array: weights, ifm prime,
// ifm stream and drain, looping over ic and oc.
module pea_ctrl
  import pea_pkg::*;
#(
  parameter int COL    = 8,
  parameter int PE_LAT = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             cfg_stride,
  input  logic [CNT_W-1:0] cfg_ic,
  input  logic [CNT_W-1:0] cfg_oc,
  input  logic [CNT_W-1:0] cfg_steps,
  input  logic             wgt_avail,
  input  logic             ifm_avail,
  output logic             busy,
  output logic             done,
  output logic             stride,
  output logic             wgt_read,
  output logic             ifm_read,
  output logic [COL-1:0]   pvalid,
  output logic             ic_done,
  output logic             oc_done
);

  pea_ctrl_state_e  state;
  pea_cfg_t         cfg;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] ic_cnt;
  logic [CNT_W-1:0] oc_cnt;

  logic     kern_last;
  logic     step_last;
  logic     ic_last;
  logic     oc_last;
  logic     step;
  logic     pend;
  pea_tag_t tag_in;
  pea_tag_t tag_out;

  assign wgt_read = (state == S_WLOAD) && wgt_avail;
  assign ifm_read = ((state == S_PRIME) || (state == S_RUN))
                    && ifm_avail;
  assign step     = (state == S_RUN) && ifm_avail;

  assign kern_last = rd_cnt == CNT_W'(KERNEL - 1);
  assign step_last = rd_cnt == CNT_W'(cfg.steps - CFG_W'(1));
  assign ic_last   = ic_cnt == CNT_W'(cfg.ic - CFG_W'(1));
  assign oc_last   = oc_cnt == CNT_W'(cfg.oc - CFG_W'(1));

  assign tag_in = '{
    step:    step,
    ic_last: step & ic_last,
    oc_last: step & ic_last & oc_last & step_last
  };

  pea_ctrl_dly #(
    .LAT (PE_LAT)
  ) u_dly (
    .clk  (clk),
    .rstn (rstn),
    .d    (tag_in),
    .q    (tag_out),
    .pend (pend)
  );

  assign pvalid  = {COL{tag_out.step}};
  assign ic_done = tag_out.ic_last;
  assign oc_done = tag_out.oc_last;
  assign stride  = cfg.stride;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      cfg    <= '0;
      rd_cnt <= '0;
      ic_cnt <= '0;
      oc_cnt <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            cfg <= '{
              stride: cfg_stride,
              ic:     nz(CFG_W'(cfg_ic)),
              oc:     nz(CFG_W'(cfg_oc)),
              steps:  nz(CFG_W'(cfg_steps))
            };
            busy   <= 1'b1;
            rd_cnt <= '0;
            ic_cnt <= '0;
            oc_cnt <= '0;
            state  <= S_WLOAD;
          end
        end
        S_WLOAD: begin
          if (wgt_read) begin
            if (kern_last) begin
              rd_cnt <= '0;
              state  <= S_PRIME;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
            end
          end
        end
        S_PRIME: begin
          if (ifm_read) begin
            if (kern_last) begin
              rd_cnt <= '0;
              state  <= S_RUN;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (ifm_read) begin
            if (step_last) begin
              rd_cnt <= '0;
              if (ic_last && oc_last) begin
                state <= S_DRAIN;
              end else begin
                state <= S_WLOAD;
                if (ic_last) begin
                  ic_cnt <= '0;
                  oc_cnt <= oc_cnt + 1'b1;
                end else begin
                  ic_cnt <= ic_cnt + 1'b1;
                end
              end
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
            end
          end
        end
        // Leave once only the output stage can still hold a beat.
        S_DRAIN: begin
          if (!pend) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pea_ctrl.sv
// Randomized bench for pea_ctrl against an operation-list
// reference model of the pass.
module tb_pea_ctrl;

  localparam int COL    = 8;
  localparam int PE_LAT = 2;
  localparam int CNT_W  = 8;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic             cfg_stride = 1'b0;
  logic [CNT_W-1:0] cfg_ic = '0;
  logic [CNT_W-1:0] cfg_oc = '0;
  logic [CNT_W-1:0] cfg_steps = '0;
  logic             wgt_avail = 1'b0;
  logic             ifm_avail = 1'b0;
  logic             busy;
  logic             done;
  logic             stride;
  logic             wgt_read;
  logic             ifm_read;
  logic [COL-1:0]   pvalid;
  logic             ic_done;
  logic             oc_done;

  always #5 clk = ~clk;

  pea_ctrl #(
    .COL    (COL),
    .PE_LAT (PE_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .cfg_stride (cfg_stride),
    .cfg_ic     (cfg_ic),
    .cfg_oc     (cfg_oc),
    .cfg_steps  (cfg_steps),
    .wgt_avail  (wgt_avail),
    .ifm_avail  (ifm_avail),
    .busy       (busy),
    .done       (done),
    .stride     (stride),
    .wgt_read   (wgt_read),
    .ifm_read   (ifm_read),
    .pvalid     (pvalid),
    .ic_done    (ic_done),
    .oc_done    (oc_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // kind: 0 weight load, 1 ifm prime, 2 ifm step
  typedef struct {
    int kind;
    bit icl;
    bit ocl;
  } op_t;

  typedef struct {
    int t;
    bit icl;
    bit ocl;
  } beat_t;

  op_t   ops[$];
  beat_t beats[$];
  int    n = 0;
  int    done_t = -1;
  bit    m_busy = 0;
  bit    m_stride = 0;
  int    o_w, o_b, o_icd, o_ocd, o_d;

  function automatic int one_if_zero(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic void build(input int ic, input int oc,
                                input int st);
    int IC = one_if_zero(ic);
    int OC = one_if_zero(oc);
    int S  = one_if_zero(st);
    ops.delete();
    for (int o = 0; o < OC; o++)
      for (int i = 0; i < IC; i++) begin
        for (int k = 0; k < 3; k++) ops.push_back('{0, 0, 0});
        for (int k = 0; k < 3; k++) ops.push_back('{1, 0, 0});
        for (int j = 0; j < S; j++)
          ops.push_back('{2, i == IC - 1,
                          (i == IC - 1) && (o == OC - 1)
                          && (j == S - 1)});
      end
  endfunction

  task automatic step_cycle(input bit st, input bit wa,
                            input bit ia, input bit sd,
                            input int ic, input int oc,
                            input int s);
    bit             ew, ei, bv, bic, boc, ed;
    op_t            h;
    beat_t          b;
    logic [COL-1:0] ep;
    @(negedge clk);
    start = st;
    wgt_avail = wa;
    ifm_avail = ia;
    cfg_stride = sd;
    cfg_ic = CNT_W'(ic);
    cfg_oc = CNT_W'(oc);
    cfg_steps = CNT_W'(s);
    #1;
    ew = 0; ei = 0; bv = 0; bic = 0; boc = 0;
    if (ops.size() > 0) begin
      h = ops[0];
      if (h.kind == 0) ew = wa;
      else ei = ia;
      if (ew || ei) begin
        void'(ops.pop_front());
        if (h.kind == 2)
          beats.push_back('{n + PE_LAT, h.icl, h.ocl});
        if (ops.size() == 0) done_t = n + PE_LAT + 1;
      end
    end
    if (beats.size() > 0 && beats[0].t == n) begin
      b = beats.pop_front();
      bv = 1; bic = b.icl; boc = b.ocl;
    end
    ed = (n == done_t);
    ep = bv ? '1 : '0;
    check("wgt_read", wgt_read, ew);
    check("ifm_read", ifm_read, ei);
    check("pvalid", pvalid, ep);
    check("ic_done", ic_done, bic);
    check("oc_done", oc_done, boc);
    check("done", done, ed);
    check("busy", busy, m_busy);
    check("stride", stride, m_stride);
    if (wgt_read) o_w++;
    if (pvalid == '1) o_b++;
    if (ic_done) o_icd++;
    if (oc_done) o_ocd++;
    if (done) o_d++;
    if (ed) m_busy = 0;
    else if (!m_busy && st) begin
      m_busy = 1;
      m_stride = sd;
      build(ic, oc, s);
    end
    n++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 0;
    wgt_avail = 1;
    ifm_avail = 1;
    #2 rstn = 0;
    #1;
    check("reset_outs",
          {busy, done, stride, wgt_read, ifm_read,
           pvalid, ic_done, oc_done}, '0);
    ops.delete();
    beats.delete();
    m_busy = 0;
    m_stride = 0;
    done_t = -1;
    @(negedge clk);
    rstn = 1;
  endtask

  // mode: 0 avail high, 1 ifm toggling, 2 random
  task automatic run_pass(input int ic, input int oc,
                          input int s, input bit sd,
                          input int mode, input int abort);
    int cyc = 0;
    bit wa, ia;
    bit aborted = 0;
    int IC = one_if_zero(ic);
    int OC = one_if_zero(oc);
    int S  = one_if_zero(s);
    o_w = 0; o_b = 0; o_icd = 0; o_ocd = 0; o_d = 0;
    step_cycle(1, 1, 1, sd, ic, oc, s);
    while (m_busy && cyc < 5000) begin
      if (abort > 0 && cyc == abort) begin
        do_reset();
        aborted = 1;
        break;
      end
      unique case (mode)
        0: begin wa = 1; ia = 1; end
        1: begin wa = 1; ia = (cyc % 2) == 0; end
        default: begin
          wa = $urandom_range(0, 1) == 1;
          ia = $urandom_range(0, 1) == 1;
        end
      endcase
      step_cycle($urandom_range(0, 3) == 0, wa, ia,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 255),
                 $urandom_range(0, 255), $urandom_range(0, 255));
      cyc++;
    end
    if (cyc >= 5000) check("timeout", 1, 0);
    if (!aborted) begin
      check("n_wgt_read", o_w, 3 * IC * OC);
      check("n_beats", o_b, IC * OC * S);
      check("n_ic_done", o_icd, OC * S);
      check("n_oc_done", o_ocd, 1);
      check("n_done", o_d, 1);
    end else begin
      check("abort_done", o_d, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset_outs",
          {busy, done, stride, wgt_read, ifm_read,
           pvalid, ic_done, oc_done}, '0);
    @(negedge clk);
    rstn = 1;
    run_pass(1, 1, 4, 0, 0, 0);
    run_pass(2, 2, 2, 0, 0, 0);
    run_pass(1, 1, 6, 0, 1, 0);
    run_pass(2, 1, 3, 1, 2, 0);
    run_pass(1, 1, 8, 0, 0, 10);
    run_pass(1, 1, 3, 0, 0, 0);
    run_pass(0, 0, 0, 1, 2, 0);
    for (int k = 0; k < 12; k++)
      run_pass($urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 6), $urandom_range(0, 1) == 1,
               2, 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
